// File: rtl/psg_pkg.sv
// Shared definitions for the multi-channel PSG: register map,
// ctrl/shape bit positions and the 4-bit to 10-bit volume curve.
package psg_pkg;

    localparam logic [7:0] A_NOISE   = 8'h00;
    localparam logic [7:0] A_ENV_LO  = 8'h01;
    localparam logic [7:0] A_ENV_HI  = 8'h02;
    localparam logic [7:0] A_SHAPE   = 8'h03;
    localparam logic [7:0] A_STATUS  = 8'h04;
    localparam logic [7:0] A_CH_BASE = 8'h10;

    localparam int CH_STRIDE = 4;

    localparam logic [1:0] OFS_PER_LO = 2'd0;
    localparam logic [1:0] OFS_PER_HI = 2'd1;
    localparam logic [1:0] OFS_CTRL   = 2'd2;
    localparam logic [1:0] OFS_VOL    = 2'd3;

    localparam int SH_HOLD = 0;
    localparam int SH_ALT  = 1;
    localparam int SH_ATK  = 2;
    localparam int SH_CONT = 3;

    localparam int CT_TONE  = 0;
    localparam int CT_NOISE = 1;
    localparam int CT_PANL  = 2;
    localparam int CT_PANR  = 3;

    // pan_l and pan_r set, both generators disabled
    localparam logic [3:0] CTRL_RST = 4'b1100;

    function automatic logic [9:0] vol_lut(input logic [3:0] v);
        logic [9:0] r;
        case (v)
            4'd0:    r = 10'd0;
            4'd1:    r = 10'd6;
            4'd2:    r = 10'd9;
            4'd3:    r = 10'd13;
            4'd4:    r = 10'd19;
            4'd5:    r = 10'd27;
            4'd6:    r = 10'd39;
            4'd7:    r = 10'd56;
            4'd8:    r = 10'd80;
            4'd9:    r = 10'd116;
            4'd10:   r = 10'd166;
            4'd11:   r = 10'd239;
            4'd12:   r = 10'd344;
            4'd13:   r = 10'd495;
            4'd14:   r = 10'd712;
            default: r = 10'd1023;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/psg_tone.sv
// Square-wave tone generator for one PSG channel.
// Ports: clk, reset_n, tick (advance), period, tone_out.
module psg_tone
    import psg_pkg::*;
#(
    parameter int PERIOD_W = 12
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                tick,
    input  logic [PERIOD_W-1:0] period,
    output logic                tone_out
);

    logic [PERIOD_W-1:0] r_cnt;
    logic                r_out;

    // >= so that a period written below the running count
    // forces a toggle on the next tick instead of a long wrap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_out <= 1'b0;
        end else if (tick) begin
            if (r_cnt >= period) begin
                r_cnt <= '0;
                r_out <= ~r_out;
            end else begin
                r_cnt <= r_cnt + PERIOD_W'(1);
            end
        end
    end

    assign tone_out = r_out;

endmodule

// File: rtl/psg_multi.sv
// NUM_CH-channel PSG: tones, shared noise and envelope, stereo mix.
// Ports: clk, reset_n, a0/wren/wrdata bus, rddata, audio_l/r, env_stopped.
module psg_multi
    import psg_pkg::*;
#(
    parameter  int NUM_CH   = 6,
    parameter  int PERIOD_W = 12,
    parameter  int DIV      = 128,
    localparam int OUT_W    = 10 + $clog2(NUM_CH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             a0,
    input  logic             wren,
    input  logic [7:0]       wrdata,
    output logic [7:0]       rddata,
    output logic [OUT_W-1:0] audio_l,
    output logic [OUT_W-1:0] audio_r,
    output logic             env_stopped
);

    localparam int PW = $clog2(DIV);

    logic [PW-1:0]       r_presc;
    logic [7:0]          r_addr;
    logic [4:0]          r_nper;
    logic [15:0]         r_eper;
    logic [3:0]          r_shape;
    logic [PERIOD_W-1:0] r_per  [NUM_CH];
    logic [3:0]          r_ctrl [NUM_CH];
    logic [4:0]          r_vol  [NUM_CH];
    logic [4:0]          r_ncnt;
    logic                r_nprs;
    logic [16:0]         r_lfsr;
    logic [16:0]         r_ecnt;
    logic [3:0]          r_elvl;
    logic                r_edir;
    logic                r_estop;
    logic [OUT_W-1:0]    r_audio_l;
    logic [OUT_W-1:0]    r_audio_r;

    logic              w_tick;
    logic              w_wr;
    logic              w_in_ch;
    logic [7:0]        w_off;
    logic [5:0]        w_ch;
    logic [1:0]        w_fld;
    logic              w_shape_wr;
    logic              w_estep;
    logic              w_eend;
    logic [NUM_CH-1:0] w_tone;
    logic [9:0]        w_amp [NUM_CH];
    logic [OUT_W-1:0]  w_sum_l;
    logic [OUT_W-1:0]  w_sum_r;

    assign w_tick     = (r_presc == '0);
    assign w_wr       = wren && !a0;
    assign w_in_ch    = (r_addr >= A_CH_BASE);
    assign w_off      = r_addr - A_CH_BASE;
    assign w_ch       = w_off[7:2];
    assign w_fld      = w_off[1:0];
    assign w_shape_wr = w_wr && (r_addr == A_SHAPE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_presc <= '0;
        else          r_presc <= r_presc + PW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr  <= '0;
            r_nper  <= '0;
            r_eper  <= '0;
            r_shape <= '0;
        end else begin
            if (wren && a0) r_addr <= wrdata;
            if (w_wr) begin
                case (r_addr)
                    A_NOISE:  r_nper       <= wrdata[4:0];
                    A_ENV_LO: r_eper[7:0]  <= wrdata;
                    A_ENV_HI: r_eper[15:8] <= wrdata;
                    A_SHAPE:  r_shape      <= wrdata[3:0];
                    default:  ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_per[c]  <= '0;
                r_ctrl[c] <= CTRL_RST;
                r_vol[c]  <= '0;
            end
        end else if (w_wr && w_in_ch) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_ch == 6'(c)) begin
                    unique case (w_fld)
                        OFS_PER_LO: r_per[c][7:0] <= wrdata;
                        OFS_PER_HI: r_per[c][PERIOD_W-1:8] <=
                                    wrdata[PERIOD_W-9:0];
                        OFS_CTRL:   r_ctrl[c] <= wrdata[3:0];
                        OFS_VOL:    r_vol[c]  <= wrdata[4:0];
                    endcase
                end
            end
        end
    end

    always_comb begin
        rddata = '0;
        if (w_in_ch) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_ch == 6'(c)) begin
                    unique case (w_fld)
                        OFS_PER_LO: rddata = r_per[c][7:0];
                        OFS_PER_HI: rddata = 8'(r_per[c][PERIOD_W-1:8]);
                        OFS_CTRL:   rddata = {4'b0, r_ctrl[c]};
                        OFS_VOL:    rddata = {3'b0, r_vol[c]};
                    endcase
                end
            end
        end else begin
            case (r_addr)
                A_NOISE:  rddata = {3'b0, r_nper};
                A_ENV_LO: rddata = r_eper[7:0];
                A_ENV_HI: rddata = r_eper[15:8];
                A_SHAPE:  rddata = {4'b0, r_shape};
                A_STATUS: rddata = {7'b0, r_estop};
                default:  rddata = '0;
            endcase
        end
    end

    // r_nprs halves the wrap rate so the LFSR moves every second wrap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ncnt <= '0;
            r_nprs <= 1'b0;
            r_lfsr <= 17'h1;
        end else if (w_tick) begin
            if (r_ncnt >= r_nper) begin
                r_ncnt <= '0;
                r_nprs <= ~r_nprs;
                if (r_nprs) r_lfsr <= {r_lfsr[0] ^ r_lfsr[3], r_lfsr[16:1]};
            end else begin
                r_ncnt <= r_ncnt + 5'd1;
            end
        end
    end

    // >= keeps the counter inside 0..2P after a period shrink
    assign w_estep = w_tick && (r_ecnt >= {r_eper, 1'b0});
    assign w_eend  = r_edir ? (r_elvl == 4'hF) : (r_elvl == 4'h0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ecnt  <= '0;
            r_elvl  <= '0;
            r_edir  <= 1'b0;
            r_estop <= 1'b1;
        end else if (w_shape_wr) begin
            r_ecnt  <= '0;
            r_elvl  <= wrdata[SH_ATK] ? 4'h0 : 4'hF;
            r_edir  <= wrdata[SH_ATK];
            r_estop <= 1'b0;
        end else if (w_tick) begin
            r_ecnt <= w_estep ? '0 : r_ecnt + 17'd1;
            if (w_estep && !r_estop) begin
                if (!w_eend) begin
                    r_elvl <= r_edir ? r_elvl + 4'd1 : r_elvl - 4'd1;
                end else if (!r_shape[SH_CONT]) begin
                    r_elvl  <= 4'h0;
                    r_estop <= 1'b1;
                end else if (r_shape[SH_HOLD]) begin
                    r_elvl  <= r_elvl ^ {4{r_shape[SH_ALT]}};
                    r_estop <= 1'b1;
                end else if (r_shape[SH_ALT]) begin
                    r_edir <= ~r_edir;
                end else begin
                    r_elvl <= r_edir ? 4'h0 : 4'hF;
                end
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic       w_gate;
        logic [3:0] w_vsel;

        psg_tone #(.PERIOD_W(PERIOD_W)) u_tone (
            .clk      (clk),
            .reset_n  (reset_n),
            .tick     (w_tick),
            .period   (r_per[c]),
            .tone_out (w_tone[c])
        );

        // a disabled generator passes 1, so both off gives DC volume
        assign w_gate = (w_tone[c] | ~r_ctrl[c][CT_TONE]) &
                        (r_lfsr[0] | ~r_ctrl[c][CT_NOISE]);
        assign w_vsel = r_vol[c][4] ? r_elvl : r_vol[c][3:0];
        assign w_amp[c] = w_gate ? vol_lut(w_vsel) : 10'd0;
    end

    always_comb begin
        w_sum_l = '0;
        w_sum_r = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_sum_l = w_sum_l +
                      (r_ctrl[c][CT_PANL] ? OUT_W'(w_amp[c]) : '0);
            w_sum_r = w_sum_r +
                      (r_ctrl[c][CT_PANR] ? OUT_W'(w_amp[c]) : '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_audio_l <= '0;
            r_audio_r <= '0;
        end else if (w_tick) begin
            r_audio_l <= w_sum_l;
            r_audio_r <= w_sum_r;
        end
    end

    assign audio_l     = r_audio_l;
    assign audio_r     = r_audio_r;
    assign env_stopped = r_estop;

endmodule

// File: tb/tb_psg_multi.sv
// Self-checking bench for psg_multi (3 channels, DIV=4).
// Table-driven register/mixer vectors plus envelope/noise sequences.
module tb_psg_multi;

    localparam int NUM_CH   = 3;
    localparam int PERIOD_W = 12;
    localparam int DIV      = 4;
    localparam int OUT_W    = 12;

    logic             clk     = 1'b0;
    logic             reset_n = 1'b0;
    logic             a0      = 1'b0;
    logic             wren    = 1'b0;
    logic [7:0]       wrdata  = 8'h00;
    logic [7:0]       rddata;
    logic [OUT_W-1:0] audio_l;
    logic [OUT_W-1:0] audio_r;
    logic             env_stopped;

    psg_multi #(
        .NUM_CH   (NUM_CH),
        .PERIOD_W (PERIOD_W),
        .DIV      (DIV)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .a0          (a0),
        .wren        (wren),
        .wrdata      (wrdata),
        .rddata      (rddata),
        .audio_l     (audio_l),
        .audio_r     (audio_r),
        .env_stopped (env_stopped)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int edges = 0;
    int sb[$];

    int lut [16] = '{0, 6, 9, 13, 19, 27, 39, 56,
                     80, 116, 166, 239, 344, 495, 712, 1023};

    typedef struct packed {
        logic [7:0] addr;
        logic       wr;
        logic [7:0] data;
        logic [7:0] exp;
    } rb_t;

    typedef struct packed {
        logic [7:0]  v0;
        logic [7:0]  v1;
        logic [7:0]  v2;
        logic [7:0]  c0;
        logic [7:0]  c1;
        logic [7:0]  c2;
        logic [15:0] el;
        logic [15:0] er;
    } mx_t;

    rb_t rb [16];
    mx_t mx [6];

    task automatic clk1();
        @(posedge clk);
        edges++;
        #1;
    endtask

    task automatic wr(input logic is_addr, input logic [7:0] d);
        a0     = is_addr;
        wren   = 1'b1;
        wrdata = d;
        clk1();
        wren = 1'b0;
        a0   = 1'b0;
    endtask

    task automatic reg_wr(input logic [7:0] ad, input logic [7:0] d);
        wr(1'b1, ad);
        wr(1'b0, d);
    endtask

    // returns just after the next prescaler tick edge
    task automatic next_tick();
        do clk1();
        while (((edges - 1) % DIV) != 0);
    endtask

    task automatic do_reset();
        wren    = 1'b0;
        a0      = 1'b0;
        wrdata  = 8'h00;
        reset_n = 1'b0;
        clk1();
        clk1();
        reset_n = 1'b1;
        edges   = 0;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic sb_check(input string nm, input int act);
        int e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got %0d", nm, act);
        end else begin
            e = sb.pop_front();
            check(nm, act, e);
        end
    endtask

    function automatic int tri_lvl(input int j);
        int m;
        m = j % 32;
        return (m < 16) ? 15 - m : m - 16;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [16:0] lf;
        int          nbit [24];
        bit          found;

        rb[0]  = '{8'h12, 1'b0, 8'h00, 8'h0C};
        rb[1]  = '{8'h04, 1'b0, 8'h00, 8'h01};
        rb[2]  = '{8'h00, 1'b1, 8'hFF, 8'h1F};
        rb[3]  = '{8'h01, 1'b1, 8'hA5, 8'hA5};
        rb[4]  = '{8'h02, 1'b1, 8'h3C, 8'h3C};
        rb[5]  = '{8'h10, 1'b1, 8'h5A, 8'h5A};
        rb[6]  = '{8'h11, 1'b1, 8'hFF, 8'h0F};
        rb[7]  = '{8'h13, 1'b1, 8'hFF, 8'h1F};
        rb[8]  = '{8'h16, 1'b1, 8'hF3, 8'h03};
        rb[9]  = '{8'h1C, 1'b1, 8'hFF, 8'h00};
        rb[10] = '{8'h05, 1'b1, 8'hFF, 8'h00};
        rb[11] = '{8'h04, 1'b1, 8'h00, 8'h01};
        rb[12] = '{8'h03, 1'b1, 8'hF9, 8'h09};
        rb[13] = '{8'h04, 1'b0, 8'h00, 8'h00};
        rb[14] = '{8'h1B, 1'b1, 8'h8E, 8'h0E};
        rb[15] = '{8'h0F, 1'b0, 8'h00, 8'h00};

        mx[0] = '{8'h0F, 8'h0F, 8'h0F, 8'h0C, 8'h0C, 8'h0C, 16'd3069, 16'd3069};
        mx[1] = '{8'h0F, 8'h08, 8'h01, 8'h04, 8'h08, 8'h0C, 16'd1029, 16'd86};
        mx[2] = '{8'h00, 8'h07, 8'h0C, 8'h0C, 8'h0C, 8'h00, 16'd56,   16'd56};
        mx[3] = '{8'h04, 8'h04, 8'h04, 8'h0C, 8'h04, 8'h08, 16'd38,   16'd38};
        mx[4] = '{8'h0A, 8'h0B, 8'h0D, 8'h04, 8'h04, 8'h04, 16'd900,  16'd0};
        mx[5] = '{8'h1F, 8'h0E, 8'h00, 8'h0C, 8'h08, 8'h0C, 16'd0,    16'd712};

        // reset state
        do_reset();
        sb.push_back(0);
        sb.push_back(0);
        sb.push_back(1);
        sb_check("rst_audio_l", int'(audio_l));
        sb_check("rst_audio_r", int'(audio_r));
        sb_check("rst_env_stopped", int'(env_stopped));

        // register readback table
        for (int i = 0; i < 16; i++) begin
            wr(1'b1, rb[i].addr);
            if (rb[i].wr) wr(1'b0, rb[i].data);
            sb.push_back(int'(rb[i].exp));
            sb_check($sformatf("rd_%02h_v%0d", rb[i].addr, i), int'(rddata));
        end

        // DC mixer / panning table
        do_reset();
        for (int i = 0; i < 6; i++) begin
            reg_wr(8'h13, mx[i].v0);
            reg_wr(8'h12, mx[i].c0);
            reg_wr(8'h17, mx[i].v1);
            reg_wr(8'h16, mx[i].c1);
            reg_wr(8'h1B, mx[i].v2);
            reg_wr(8'h1A, mx[i].c2);
            sb.push_back(int'(mx[i].el));
            sb.push_back(int'(mx[i].er));
            next_tick();
            next_tick();
            sb_check($sformatf("mix_l_v%0d", i), int'(audio_l));
            sb_check($sformatf("mix_r_v%0d", i), int'(audio_r));
        end

        // tone: period 2, left only, toggles every 3 ticks
        do_reset();
        reg_wr(8'h13, 8'h0F);
        reg_wr(8'h12, 8'h05);
        reg_wr(8'h10, 8'h02);
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            next_tick();
            if (audio_l != '0) found = 1'b1;
        end
        if (!found) begin
            n_vec++;
            n_err++;
            $display("FAIL tone_start: audio_l stayed 0, expected 1023");
        end else begin
            for (int i = 0; i < 12; i++) begin
                sb.push_back(((i / 3) % 2 == 0) ? 1023 : 0);
                sb.push_back(0);
            end
            for (int i = 0; i < 12; i++) begin
                if (i != 0) next_tick();
                sb_check($sformatf("tone_l_t%0d", i), int'(audio_l));
                sb_check($sformatf("tone_r_t%0d", i), int'(audio_r));
            end
        end

        // envelope attack + hold
        do_reset();
        reg_wr(8'h13, 8'h10);
        reg_wr(8'h03, 8'h0D);
        for (int j = 0; j < 20; j++) begin
            sb.push_back(lut[(j > 15) ? 15 : j]);
            sb.push_back(lut[(j > 15) ? 15 : j]);
            sb.push_back((j >= 15) ? 1 : 0);
        end
        for (int j = 0; j < 20; j++) begin
            next_tick();
            sb_check($sformatf("hold_l_t%0d", j), int'(audio_l));
            sb_check($sformatf("hold_r_t%0d", j), int'(audio_r));
            sb_check($sformatf("hold_stop_t%0d", j), int'(env_stopped));
        end
        wr(1'b1, 8'h04);
        sb.push_back(1);
        sb_check("hold_status", int'(rddata));

        // envelope triangle
        do_reset();
        reg_wr(8'h13, 8'h10);
        reg_wr(8'h03, 8'h0A);
        for (int j = 0; j < 40; j++) begin
            sb.push_back(lut[tri_lvl(j)]);
            sb.push_back(0);
        end
        for (int j = 0; j < 40; j++) begin
            next_tick();
            sb_check($sformatf("tri_l_t%0d", j), int'(audio_l));
            sb_check($sformatf("tri_stop_t%0d", j), int'(env_stopped));
        end
        // shape rewrite landing on a step tick
        while ((edges % DIV) != (DIV - 1)) clk1();
        wr(1'b1, 8'h03);
        wr(1'b0, 8'h0A);
        sb.push_back(lut[tri_lvl(40)]);
        sb_check("tri_rw_tick", int'(audio_l));
        for (int j = 0; j < 5; j++) sb.push_back(lut[15 - j]);
        for (int j = 0; j < 5; j++) begin
            next_tick();
            sb_check($sformatf("tri_rw_t%0d", j), int'(audio_l));
        end

        // asynchronous reset between clock edges
        reset_n = 1'b0;
        #1;
        sb.push_back(0);
        sb.push_back(0);
        sb.push_back(1);
        sb_check("async_audio_l", int'(audio_l));
        sb_check("async_audio_r", int'(audio_r));
        sb_check("async_env_stopped", int'(env_stopped));

        // noise only, period 0
        do_reset();
        reg_wr(8'h13, 8'h0F);
        reg_wr(8'h12, 8'h0E);
        lf = 17'h1;
        for (int n = 0; n < 24; n++) begin
            nbit[n] = int'(lf[0]);
            lf = {lf[0] ^ lf[3], lf[16:1]};
        end
        for (int k = 1; k <= 40; k++) begin
            sb.push_back((nbit[k / 2] != 0) ? 1023 : 0);
        end
        for (int k = 1; k <= 40; k++) begin
            next_tick();
            sb_check($sformatf("noise_t%0d", k), int'(audio_l));
        end

        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_left: %0d entries, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
